// File: rtl/signed_mul_pkg.sv
//==============================================================================
// Module  : signed_mul_pkg
// Brief   : Shared constants, state encoding and helpers for signed_seq_multiplier.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package signed_mul_pkg;

    localparam int SMUL_WIDTH = 32;

    typedef logic [1:0] smul_state_t;

    localparam smul_state_t ST_IDLE = 2'd0;
    localparam smul_state_t ST_CALC = 2'd1;
    localparam smul_state_t ST_FIX  = 2'd2;
    localparam smul_state_t ST_DONE = 2'd3;

    // Iteration counter must be able to hold the value WIDTH itself.
    function automatic int smul_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sign_magnitude_conv.sv
//==============================================================================
// Module  : sign_magnitude_conv
// Brief   : Conditional two's-complement negate (val_o = neg_i ? -val_i : val_i).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sign_magnitude_conv #(
    parameter int N = 32
) (
    input  logic [N-1:0] val_i,
    input  logic         neg_i,
    output logic [N-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + 1'b1) : val_i;

endmodule

`default_nettype wire

// File: rtl/signed_seq_multiplier.sv
//==============================================================================
// Module  : signed_seq_multiplier
// Brief   : Iterative radix-2 signed multiplier, WIDTH x WIDTH -> 2*WIDTH,
//           start/done handshake. Optional macro: SMUL_EARLY_TERM_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module signed_seq_multiplier
    import signed_mul_pkg::*;
#(
    parameter int WIDTH = SMUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2
);

    localparam int              CW     = smul_cnt_width(WIDTH);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    smul_state_t      state_q, state_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             neg_q,   neg_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out1_q,  out1_d;
    logic [WIDTH-1:0] out2_q,  out2_d;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] fixed_prod;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;

    sign_magnitude_conv #(.N(WIDTH)) u_abs_a (
        .val_i (A),
        .neg_i (A[WIDTH-1]),
        .val_o (abs_a)
    );

    sign_magnitude_conv #(.N(WIDTH)) u_abs_b (
        .val_i (B),
        .neg_i (B[WIDTH-1]),
        .val_o (abs_b)
    );

    sign_magnitude_conv #(.N(2*WIDTH)) u_fix (
        .val_i ({acc_q, mag_b_q}),
        .neg_i (neg_q),
        .val_o (fixed_prod)
    );

    assign addend = mag_b_q[0] ? mag_a_q : '0;
    assign sum    = {1'b0, acc_q} + {1'b0, addend};

`ifdef SMUL_EARLY_TERM_EN
    localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);

    logic [WIDTH-1:0]   live_mask;
    logic               rest_zero;
    logic [CW-1:0]      remaining;
    logic [2*WIDTH-1:0] skip_prod;

    // After count shifts, the low WIDTH-count bits of mag_b are still multiplier bits.
    assign live_mask = {WIDTH{1'b1}} >> count_q;
    assign rest_zero = (mag_b_q & live_mask) == '0;
    assign remaining = C_WIDTH - count_q;
    assign skip_prod = {acc_q, mag_b_q} >> remaining;
`endif

    always_comb begin
        state_d = state_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        count_d = count_q;
        out1_d  = out1_q;
        out2_d  = out2_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mag_a_d = abs_a;
                    mag_b_d = abs_b;
                    neg_d   = A[WIDTH-1] ^ B[WIDTH-1];
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ST_CALC;
                end
            end

            ST_CALC: begin
`ifdef SMUL_EARLY_TERM_EN
                if (rest_zero) begin
                    {acc_d, mag_b_d} = skip_prod;
                    state_d          = ST_FIX;
                end else begin
                    acc_d   = sum[WIDTH:1];
                    mag_b_d = {sum[0], mag_b_q[WIDTH-1:1]};
                    count_d = count_q + 1'b1;
                    if (count_q == C_LAST) begin
                        state_d = ST_FIX;
                    end
                end
`else
                acc_d   = sum[WIDTH:1];
                mag_b_d = {sum[0], mag_b_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == C_LAST) begin
                    state_d = ST_FIX;
                end
`endif
            end

            ST_FIX: begin
                // Outputs load with the signed product here so they are valid while done is high.
                {acc_d, mag_b_d} = fixed_prod;
                out1_d           = fixed_prod[2*WIDTH-1:WIDTH];
                out2_d           = fixed_prod[WIDTH-1:0];
                state_d          = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            count_q <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            count_q <= count_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
        end
    end

    assign busy = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done = (state_q == ST_DONE);
    assign out1 = out1_q;
    assign out2 = out2_q;

endmodule

`default_nettype wire
